// File: rtl/melody_player.sv
// melody_player: score sequencer feeding the tone/octave/volume audio top.
// It walks a combinational score memory. For each entry it drives the decoded
// left/right frequencies in Hz for dur beats, minus a trailing articulation gap of rest.
// Playback supports start, stop, pause/resume and looping.
module melody_player #(
    parameter int unsigned TICK_DIV   = 12500000,
    parameter int unsigned GAP_CYCLES = 1250000,
    parameter int unsigned SONG_LEN   = 64,
    parameter int unsigned ADDR_W     = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] note_addr,
    input  logic [13:0]       note_data,
    output logic [31:0]       freq_left,
    output logic [31:0]       freq_right,
    output logic              playing,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_GAP,
        S_PAUSE
    } state_t;

    localparam int unsigned       TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]     TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0]     HOLD_LAST = TW'(TICK_DIV - 1 - GAP_CYCLES);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SONG_LEN - 1);
    localparam logic [31:0]       REST_HZ   = 32'd50000000;

    function automatic logic [31:0] code_to_hz(input logic [4:0] code);
        logic [31:0] hz;
        case (code)
            5'd1:    hz = 32'd131;
            5'd2:    hz = 32'd147;
            5'd3:    hz = 32'd165;
            5'd4:    hz = 32'd174;
            5'd5:    hz = 32'd196;
            5'd6:    hz = 32'd220;
            5'd7:    hz = 32'd247;
            5'd8:    hz = 32'd262;
            5'd9:    hz = 32'd294;
            5'd10:   hz = 32'd330;
            5'd11:   hz = 32'd349;
            5'd12:   hz = 32'd392;
            5'd13:   hz = 32'd440;
            5'd14:   hz = 32'd494;
            5'd15:   hz = 32'd524;
            5'd16:   hz = 32'd588;
            5'd17:   hz = 32'd660;
            5'd18:   hz = 32'd698;
            5'd19:   hz = 32'd784;
            5'd20:   hz = 32'd880;
            5'd21:   hz = 32'd988;
            default: hz = REST_HZ;
        endcase
        return hz;
    endfunction

    state_t             state_q, state_d, ret_q, ret_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [TW-1:0]      tick_q, tick_d, tick_next;
    logic [3:0]         beats_q, beats_d;
    logic [31:0]        note_l_q, note_l_d, note_r_q, note_r_d;
    logic [31:0]        freq_left_q, freq_left_d, freq_right_q, freq_right_d;
    logic               playing_q, playing_d, done_q, done_d;
    logic               tick_last;
    logic [3:0]         dur;

    assign dur       = note_data[13:10];
    assign tick_last = (tick_q == TICK_LAST);
    assign tick_next = tick_last ? '0 : tick_q + 1'b1;

    // Next-state: normal sequencing first, then pause, start and stop overlaid in rising priority.
    always_comb begin
        state_d  = state_q;
        ret_d    = ret_q;
        addr_d   = addr_q;
        tick_d   = tick_q;
        beats_d  = beats_q;
        note_l_d = note_l_q;
        note_r_d = note_r_q;
        done_d   = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (dur == 4'd0) begin
                    addr_d = '0;
                    if (!loop_en) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    note_l_d = code_to_hz(note_data[9:5]);
                    note_r_d = code_to_hz(note_data[4:0]);
                    beats_d  = dur;
                    tick_d   = '0;
                    state_d  = S_HOLD;
                end
            end
            S_HOLD: begin
                tick_d = tick_next;
                if (tick_last) beats_d = beats_q - 4'd1;
                if (beats_q == 4'd1 && tick_q == HOLD_LAST) state_d = S_GAP;
            end
            S_GAP: begin
                tick_d = tick_next;
                if (tick_last) begin
                    tick_d = '0;
                    if (addr_q == ADDR_LAST) begin
                        addr_d = '0;
                        if (loop_en) begin
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_PAUSE: begin
                if (pause) state_d = ret_q;
            end
            default: ;
        endcase

        // The cycle that accepts pause still advances timing; the advanced state is what resumes,
        // so paused cycles add nothing to the note length. A song ending on that cycle still ends.
        if (pause && (state_q == S_HOLD || state_q == S_GAP) && state_d != S_IDLE) begin
            ret_d   = state_d;
            state_d = S_PAUSE;
        end

        if (start) begin
            state_d = S_FETCH;
            addr_d  = '0;
            tick_d  = '0;
            beats_d = '0;
            done_d  = 1'b0;
        end

        if (stop) begin
            state_d = S_IDLE;
            addr_d  = '0;
            tick_d  = '0;
            beats_d = '0;
            done_d  = 1'b0;
        end
    end

    // Output decode from the upcoming state so the registered outputs line up with it.
    always_comb begin
        freq_left_d  = (state_d == S_HOLD) ? note_l_d : REST_HZ;
        freq_right_d = (state_d == S_HOLD) ? note_r_d : REST_HZ;
        playing_d    = (state_d == S_FETCH) || (state_d == S_HOLD) || (state_d == S_GAP);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            ret_q        <= S_IDLE;
            addr_q       <= '0;
            tick_q       <= '0;
            beats_q      <= '0;
            note_l_q     <= REST_HZ;
            note_r_q     <= REST_HZ;
            freq_left_q  <= REST_HZ;
            freq_right_q <= REST_HZ;
            playing_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            addr_q       <= addr_d;
            tick_q       <= tick_d;
            beats_q      <= beats_d;
            note_l_q     <= note_l_d;
            note_r_q     <= note_r_d;
            freq_left_q  <= freq_left_d;
            freq_right_q <= freq_right_d;
            playing_q    <= playing_d;
            done_q       <= done_d;
        end
    end

    assign note_addr  = addr_q;
    assign freq_left  = freq_left_q;
    assign freq_right = freq_right_q;
    assign playing    = playing_q;
    assign done       = done_q;

endmodule
